// File: rtl/pwm_deadtime.sv
// Complementary high/low gate-drive generator with programmable break-before-make
// dead time and a latched fault shutdown. Every output comes straight from a register.
module pwm_deadtime #(
    parameter int DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                fault,
    input  logic                fault_clr,
    output logic                out_h,
    output logic                out_l,
    output logic                dead_active,
    output logic                fault_active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DEAD    = 3'd1,
        DRIVE_H = 3'd2,
        DRIVE_L = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic                target_reg, target_next;
    logic [DT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                out_h_reg, out_h_next;
    logic                out_l_reg, out_l_next;
    logic                dead_reg, dead_next;
    logic                fault_reg, fault_next;
    logic [DT_WIDTH-1:0] load_val;

    // A zero dead time still gives one both-low cycle, so the counter never starts at 0.
    assign load_val = (dead_time == '0) ? DT_WIDTH'(1) : dead_time;

    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        cnt_next    = cnt_reg;
        out_h_next  = 1'b0;
        out_l_next  = 1'b0;
        dead_next   = 1'b0;
        fault_next  = 1'b0;

        if (fault) begin
            state_next = FAULT;
            fault_next = 1'b1;
        end else if (state_reg == FAULT) begin
            if (fault_clr) begin
                state_next = IDLE;
            end else begin
                fault_next = 1'b1;
            end
        end else if (!en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next  = DEAD;
                    target_next = pwm_in;
                    cnt_next    = load_val;
                    dead_next   = 1'b1;
                end
                DEAD: begin
                    if (pwm_in != target_reg) begin
                        // Retarget restarts the full interval, swallowing short pulses.
                        target_next = pwm_in;
                        cnt_next    = load_val;
                        dead_next   = 1'b1;
                    end else if (cnt_reg <= DT_WIDTH'(1)) begin
                        if (target_reg) begin
                            state_next = DRIVE_H;
                            out_h_next = 1'b1;
                        end else begin
                            state_next = DRIVE_L;
                            out_l_next = 1'b1;
                        end
                    end else begin
                        cnt_next  = cnt_reg - DT_WIDTH'(1);
                        dead_next = 1'b1;
                    end
                end
                DRIVE_H: begin
                    if (pwm_in) begin
                        out_h_next = 1'b1;
                    end else begin
                        state_next  = DEAD;
                        target_next = 1'b0;
                        cnt_next    = load_val;
                        dead_next   = 1'b1;
                    end
                end
                DRIVE_L: begin
                    if (!pwm_in) begin
                        out_l_next = 1'b1;
                    end else begin
                        state_next  = DEAD;
                        target_next = 1'b1;
                        cnt_next    = load_val;
                        dead_next   = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            target_reg <= 1'b0;
            cnt_reg    <= '0;
            out_h_reg  <= 1'b0;
            out_l_reg  <= 1'b0;
            dead_reg   <= 1'b0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            cnt_reg    <= cnt_next;
            out_h_reg  <= out_h_next;
            out_l_reg  <= out_l_next;
            dead_reg   <= dead_next;
            fault_reg  <= fault_next;
        end
    end

    assign out_h        = out_h_reg;
    assign out_l        = out_l_reg;
    assign dead_active  = dead_reg;
    assign fault_active = fault_reg;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: hand-derived cycle vectors through a scoreboard queue,
// async reset corner cases, then a long random run checking overlap and dead gap.
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       pwm_in;
    logic [7:0] dead_time;
    logic       fault;
    logic       fault_clr;
    logic       out_h;
    logic       out_l;
    logic       dead_active;
    logic       fault_active;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic       en;
        logic       pwm;
        logic [7:0] dt;
        logic       flt;
        logic       clr;
        logic [3:0] exp;   // {out_h, out_l, dead_active, fault_active}
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sb_q[$];

    pwm_deadtime #(.DT_WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pwm_in       (pwm_in),
        .dead_time    (dead_time),
        .fault        (fault),
        .fault_clr    (fault_clr),
        .out_h        (out_h),
        .out_l        (out_l),
        .dead_active  (dead_active),
        .fault_active (fault_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic p, input logic [7:0] d,
                       input logic f, input logic c, input logic [3:0] x);
        vec_t v;
        v.en = e; v.pwm = p; v.dt = d; v.flt = f; v.clr = c; v.exp = x;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [3:0] want;
        @(negedge clk);
        en = v.en; pwm_in = v.pwm; dead_time = v.dt; fault = v.flt; fault_clr = v.clr;
        sb_q.push_back(v.exp);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        $display("vec %0d en=%0b pwm=%0b dt=%0d flt=%0b clr=%0b -> hldf=%b", idx, v.en, v.pwm,
                 v.dt, v.flt, v.clr, {out_h, out_l, dead_active, fault_active});
        check($sformatf("vec%0d", idx), {28'd0, out_h, out_l, dead_active, fault_active},
              {28'd0, want});
    endtask

    initial begin
        logic       prev_h, prev_l, pend, pend_h;
        int         gap, min_n, hold, n_now;

        rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0; dead_time = 8'd3; fault = 1'b0; fault_clr = 1'b0;

        //  en pwm dt flt clr  {h,l,dead,flt}
        add(0, 0, 3, 0, 0, 4'b0000);   // idle while disabled
        add(1, 0, 3, 0, 0, 4'b0010);   // enter DEAD, cnt=3
        add(1, 0, 3, 0, 0, 4'b0010);
        add(1, 0, 3, 0, 0, 4'b0010);
        add(1, 0, 3, 0, 0, 4'b0100);   // DRIVE_L
        add(1, 0, 3, 0, 0, 4'b0100);
        add(1, 1, 3, 0, 0, 4'b0010);   // rise: out_l drops at once
        add(1, 1, 3, 0, 0, 4'b0010);
        add(1, 1, 3, 0, 0, 4'b0010);
        add(1, 1, 3, 0, 0, 4'b1000);   // out_h three edges later
        add(1, 1, 3, 0, 0, 4'b1000);
        add(1, 0, 5, 0, 0, 4'b0010);   // fall with dt=5
        for (int i = 0; i < 4; i++) add(1, 0, 5, 0, 0, 4'b0010);
        add(1, 0, 5, 0, 0, 4'b0100);
        add(1, 1, 5, 0, 0, 4'b0010);   // 3-cycle pulse gets swallowed
        add(1, 1, 5, 0, 0, 4'b0010);
        add(1, 1, 5, 0, 0, 4'b0010);
        add(1, 0, 5, 0, 0, 4'b0010);   // retarget, reload 5
        for (int i = 0; i < 4; i++) add(1, 0, 5, 0, 0, 4'b0010);
        add(1, 0, 5, 0, 0, 4'b0100);   // out_l back 5 edges after fall
        add(1, 1, 0, 0, 0, 4'b0010);   // dt=0 acts as 1
        add(1, 1, 0, 0, 0, 4'b1000);
        add(1, 0, 0, 0, 0, 4'b0010);
        add(1, 0, 0, 0, 0, 4'b0100);
        add(1, 1, 2, 0, 0, 4'b0010);   // dt sampled at entry only
        add(1, 1, 7, 0, 0, 4'b0010);
        add(1, 1, 7, 0, 0, 4'b1000);
        add(1, 1, 2, 1, 0, 4'b0001);   // fault during DRIVE_H
        add(1, 1, 2, 1, 1, 4'b0001);   // clr while fault held: stays
        add(1, 1, 2, 0, 0, 4'b0001);
        add(1, 1, 2, 0, 1, 4'b0000);   // cleared -> IDLE
        add(1, 1, 2, 0, 0, 4'b0010);
        add(1, 1, 2, 0, 0, 4'b0010);
        add(1, 1, 2, 0, 0, 4'b1000);   // resumed
        add(1, 0, 4, 0, 0, 4'b0010);
        add(0, 0, 4, 0, 0, 4'b0000);   // en low mid-DEAD
        add(0, 0, 4, 0, 0, 4'b0000);
        add(1, 0, 1, 0, 0, 4'b0010);
        add(1, 0, 1, 0, 0, 4'b0100);
        add(1, 0, 1, 0, 1, 4'b0100);   // stray clr ignored
        add(0, 0, 1, 1, 0, 4'b0001);   // fault beats en=0
        add(0, 0, 1, 0, 1, 4'b0000);
        add(1, 1, 1, 0, 0, 4'b0010);
        add(1, 1, 1, 0, 0, 4'b1000);   // DRIVE_H for the reset test

        #2;
        check("reset_state", {28'd0, out_h, out_l, dead_active, fault_active}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset mid-DRIVE_H, sampled before the next edge.
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-drive -> hldf=%b", {out_h, out_l, dead_active, fault_active});
        check("rst_mid_drive", {28'd0, out_h, out_l, dead_active, fault_active}, 32'd0);

        // Asynchronous reset while a fault is latched.
        @(negedge clk);
        rst_n = 1'b1; fault = 1'b1; fault_clr = 1'b0;
        @(posedge clk);
        #1;
        check("fault_latched", {31'd0, fault_active}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-fault -> hldf=%b", {out_h, out_l, dead_active, fault_active});
        check("rst_mid_fault", {28'd0, out_h, out_l, dead_active, fault_active}, 32'd0);

        // Random run: no overlap, and both-low gap >= smallest dead time seen while waiting.
        @(negedge clk);
        rst_n = 1'b1; fault = 1'b0; en = 1'b1; pwm_in = 1'b0; dead_time = 8'd3;
        prev_h = 1'b0; prev_l = 1'b0; pend = 1'b0; pend_h = 1'b0;
        gap = 0; min_n = 0; hold = 4;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                pwm_in = ~pwm_in;
                hold = $urandom_range(1, 15);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 7) == 0) dead_time = 8'($urandom_range(0, 6));
            n_now = (dead_time == 8'd0) ? 1 : int'(dead_time);
            @(posedge clk);
            #1;
            check($sformatf("overlap_c%0d", c), {31'd0, out_h & out_l}, 32'd0);
            if ((prev_h && !out_h) || (prev_l && !out_l)) begin
                pend = 1'b1; pend_h = prev_h; gap = 1; min_n = n_now;
            end else if (pend) begin
                if (!out_h && !out_l) begin
                    gap++;
                    if (n_now < min_n) min_n = n_now;
                end else begin
                    if ((pend_h && out_l) || (!pend_h && out_h)) begin
                        $display("transition c=%0d gap=%0d min_n=%0d", c, gap, min_n);
                        check($sformatf("gap_c%0d", c), {31'd0, gap >= min_n}, 32'd1);
                    end
                    pend = 1'b0;
                end
            end
            prev_h = out_h;
            prev_l = out_l;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
